// File: rtl/alu_16bit.sv
// Registered integer ALU: add, subtract, unsigned compare, bitwise logic and a
// 1-bit right shift through the carry. The arithmetic uses 4-bit carry-lookahead slices.
module alu_16bit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] args,
  input  logic               carry_in,
  input  logic               carry_disable,
  input  logic [2:0]         cmd,
  output logic [WIDTH-1:0]   res,
  output logic               carry_out
);

  localparam int NSLICE = WIDTH / 4;

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_SUB   = 3'd1,
    CMD_AND   = 3'd2,
    CMD_OR    = 3'd3,
    CMD_XOR   = 3'd4,
    CMD_XNOR  = 3'd5,
    CMD_COMP  = 3'd6,
    CMD_RSHFT = 3'd7
  } cmd_e;

  cmd_e             w_cmd;
  logic [WIDTH-1:0] w_d1;
  logic [WIDTH-1:0] w_d2;
  logic [WIDTH-1:0] w_b;
  logic             w_isSub;
  logic             w_c0;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [NSLICE-1:0] w_groupG;
  logic [NSLICE-1:0] w_groupP;
  logic [NSLICE:0]   w_carry;
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  w_nextRes;
  logic              w_nextCarry;
  logic [WIDTH-1:0]  r_res;
  logic              r_carry;

  assign w_cmd   = cmd_e'(cmd);
  assign w_d1    = args[2*WIDTH-1:WIDTH];
  assign w_d2    = args[WIDTH-1:0];
  assign w_isSub = (w_cmd == CMD_SUB) || (w_cmd == CMD_COMP);
  assign w_b     = w_isSub ? ~w_d2 : w_d2;
  // Subtract-type commands default to carry 1 (no borrow); add and shift default to 0.
  assign w_c0    = carry_disable ? w_isSub : carry_in;
  assign w_g     = w_d1 & w_b;
  assign w_p     = w_d1 ^ w_b;

  // Slice group terms, slice-level lookahead chain, then in-slice lookahead carries.
  always_comb begin
    w_groupG = '0;
    w_groupP = '0;
    w_carry  = '0;
    w_sum    = '0;
    w_carry[0] = w_c0;
    for (int s = 0; s < NSLICE; s++) begin
      w_groupG[s] = w_g[4*s+3]
                  | (w_p[4*s+3] & w_g[4*s+2])
                  | (w_p[4*s+3] & w_p[4*s+2] & w_g[4*s+1])
                  | (w_p[4*s+3] & w_p[4*s+2] & w_p[4*s+1] & w_g[4*s]);
      w_groupP[s] = &w_p[4*s +: 4];
      w_carry[s+1] = w_groupG[s] | (w_groupP[s] & w_carry[s]);

      w_sum[4*s]   = w_p[4*s] ^ w_carry[s];
      w_sum[4*s+1] = w_p[4*s+1] ^ (w_g[4*s] | (w_p[4*s] & w_carry[s]));
      w_sum[4*s+2] = w_p[4*s+2] ^ (w_g[4*s+1] | (w_p[4*s+1] & w_g[4*s])
                                 | (w_p[4*s+1] & w_p[4*s] & w_carry[s]));
      w_sum[4*s+3] = w_p[4*s+3] ^ (w_g[4*s+2] | (w_p[4*s+2] & w_g[4*s+1])
                                 | (w_p[4*s+2] & w_p[4*s+1] & w_g[4*s])
                                 | (w_p[4*s+2] & w_p[4*s+1] & w_p[4*s] & w_carry[s]));
    end
  end

  // With c0=1 the carry means d1>=d2, so equality (zero difference) is masked for COMP.
  always_comb begin
    w_nextRes   = w_sum;
    w_nextCarry = 1'b0;
    unique case (w_cmd)
      CMD_ADD, CMD_SUB: w_nextCarry = w_carry[NSLICE];
      CMD_COMP:         w_nextCarry = w_c0 ? (w_carry[NSLICE] & (|w_sum)) : w_carry[NSLICE];
      CMD_AND:          w_nextRes   = w_d1 & w_d2;
      CMD_OR:           w_nextRes   = w_d1 | w_d2;
      CMD_XOR:          w_nextRes   = w_d1 ^ w_d2;
      CMD_XNOR:         w_nextRes   = ~(w_d1 ^ w_d2);
      CMD_RSHFT: begin
        w_nextRes   = {w_c0, w_d2[WIDTH-1:1]};
        w_nextCarry = w_d2[0];
      end
      default: begin
        w_nextRes   = w_sum;
        w_nextCarry = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_res   <= w_nextRes;
      r_carry <= w_nextCarry;
    end
  end

  assign res       = r_res;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed cases plus back-to-back randomized
// sweeps checked against an arithmetic reference model.
module tb_alu_16bit;

  logic        clk;
  logic        rst;
  logic [31:0] args;
  logic        carry_in;
  logic        carry_disable;
  logic [2:0]  cmd;
  logic [15:0] res;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, XNOR_ = 3'd5, COMP = 3'd6, RSHFT = 3'd7;

  alu_16bit #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .args         (args),
    .carry_in     (carry_in),
    .carry_disable(carry_disable),
    .cmd          (cmd),
    .res          (res),
    .carry_out    (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic; returns {carry_out, res}.
  function automatic logic [16:0] model(input logic [2:0] c, input int unsigned d1,
                                        input int unsigned d2, input logic ci, input logic cd);
    int unsigned c0;
    int unsigned t;
    logic [16:0] r;
    r = '0;
    case (c)
      ADD: begin
        c0 = cd ? 0 : ci;
        t  = d1 + d2 + c0;
        r  = {t[16], t[15:0]};
      end
      SUB, COMP: begin
        c0 = cd ? 1 : ci;
        t  = d1 + (32'hFFFF - d2) + c0;
        r  = {(c == SUB) ? t[16] : (d1 > d2), t[15:0]};
      end
      AND_:  begin t = d1 & d2;               r = {1'b0, t[15:0]}; end
      OR_:   begin t = d1 | d2;               r = {1'b0, t[15:0]}; end
      XOR_:  begin t = d1 ^ d2;               r = {1'b0, t[15:0]}; end
      XNOR_: begin t = 32'hFFFF - (d1 ^ d2);  r = {1'b0, t[15:0]}; end
      default: begin
        c0 = cd ? 0 : ci;
        t  = (c0 * 32'h8000) + (d2 / 2);
        r  = {d2[0], t[15:0]};
      end
    endcase
    return r;
  endfunction

  // Drive one operation and sample 1 time unit after the edge that registers it.
  task automatic applyStimulus(input logic [2:0] c, input logic [15:0] d1, input logic [15:0] d2,
                               input logic ci, input logic cd);
    cmd           = c;
    args          = {d1, d2};
    carry_in      = ci;
    carry_disable = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    applyStimulus(ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(ADD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (res !== 16'h0000 || carry_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: res=%h co=%b, expected res=0000 co=0", res, carry_out);
    end
  endtask

  task automatic test_add;
    logic [15:0] eRes [3] = '{16'h0000, 16'd256, 16'd255};
    logic        eCo  [3] = '{1'b1, 1'b0, 1'b0};
    logic [15:0] a    [3] = '{16'hFFFF, 16'd200, 16'd200};
    logic [15:0] b    [3] = '{16'h0001, 16'd55, 16'd55};
    logic        ci   [3] = '{1'b0, 1'b1, 1'b1};
    logic        cd   [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ADD, a[i], b[i], ci[i], cd[i]);
      checks++;
      if (res !== eRes[i] || carry_out !== eCo[i]) begin
        errors++;
        $display("[TB] FAIL add%0d: res=%h co=%b, expected res=%h co=%b",
                 i, res, carry_out, eRes[i], eCo[i]);
      end
    end
  endtask

  task automatic test_sub_comp;
    logic [2:0]  c    [5] = '{SUB, SUB, SUB, COMP, COMP};
    logic [15:0] a    [5] = '{16'd5, 16'd7, 16'd7, 16'd9, 16'd3};
    logic [15:0] b    [5] = '{16'd7, 16'd7, 16'd7, 16'd3, 16'd3};
    logic        ci   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        cd   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] eRes [5] = '{16'hFFFE, 16'h0000, 16'hFFFF, 16'd6, 16'h0000};
    logic        eCo  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(c[i], a[i], b[i], ci[i], cd[i]);
      checks++;
      if (res !== eRes[i] || carry_out !== eCo[i]) begin
        errors++;
        $display("[TB] FAIL subcomp%0d: res=%h co=%b, expected res=%h co=%b",
                 i, res, carry_out, eRes[i], eCo[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [2:0]  c    [4] = '{AND_, OR_, XOR_, XNOR_};
    logic [15:0] eRes [4] = '{16'h00F0, 16'h0FF0, 16'h0F00, 16'hF0FF};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(c[i], 16'h00F0, 16'h0FF0, 1'b1, 1'b0);
      checks++;
      if (res !== eRes[i] || carry_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL logic%0d: res=%h co=%b, expected res=%h co=0",
                 i, res, carry_out, eRes[i]);
      end
    end
  endtask

  task automatic test_rshft;
    logic        ci   [3] = '{1'b0, 1'b1, 1'b1};
    logic        cd   [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] eRes [3] = '{16'h007F, 16'h807F, 16'h007F};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(RSHFT, 16'hABCD, 16'h00FF, ci[i], cd[i]);
      checks++;
      if (res !== eRes[i] || carry_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rshft%0d: res=%h co=%b, expected res=%h co=1",
                 i, res, carry_out, eRes[i]);
      end
    end
  endtask

  // One op per cycle over a dense low-value grid, every command each step.
  task automatic test_back_to_back;
    logic [16:0] exp;
    logic ci, cd;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        for (int c = 0; c < 8; c++) begin
          ci  = 1'($urandom_range(0, 1));
          cd  = 1'($urandom_range(0, 1));
          exp = model(3'(c), a * 7, b * 7 + a % 3, ci, cd);
          applyStimulus(3'(c), 16'(a * 7), 16'(b * 7 + a % 3), ci, cd);
          checks++;
          if ({carry_out, res} !== exp) begin
            errors++;
            $display("[TB] FAIL sweep cmd=%0d d1=%0d d2=%0d ci=%b cd=%b: got co=%b res=%h, expected co=%b res=%h",
                     c, a * 7, b * 7 + a % 3, ci, cd, carry_out, res, exp[16], exp[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [16:0] exp;
    logic [15:0] a, b;
    logic [2:0]  c;
    logic        ci, cd;
    for (int i = 0; i < 4000; i++) begin
      a  = 16'($urandom);
      b  = (i % 4 == 0) ? a : 16'($urandom);
      if (i % 2 == 1) begin
        a = 16'($urandom_range(0, 255));
        b = 16'($urandom_range(0, 255));
      end
      c  = 3'($urandom_range(0, 7));
      ci = 1'($urandom_range(0, 1));
      cd = 1'($urandom_range(0, 1));
      exp = model(c, a, b, ci, cd);
      applyStimulus(c, a, b, ci, cd);
      checks++;
      if ({carry_out, res} !== exp) begin
        errors++;
        $display("[TB] FAIL random cmd=%0d d1=%h d2=%h ci=%b cd=%b: got co=%b res=%h, expected co=%b res=%h",
                 c, a, b, ci, cd, carry_out, res, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_reset_wins;
    applyStimulus(ADD, 16'h8000, 16'h8001, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(SUB, 16'h0009, 16'h0002, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (res !== 16'h0000 || carry_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wins: res=%h co=%b, expected res=0000 co=0", res, carry_out);
    end
    applyStimulus(SUB, 16'h0009, 16'h0002, 1'b1, 1'b0);
    checks++;
    if (res !== 16'h0007 || carry_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset: res=%h co=%b, expected res=0007 co=1", res, carry_out);
    end
  endtask

  initial begin
    rst           = 1'b1;
    args          = '0;
    carry_in      = 1'b0;
    carry_disable = 1'b0;
    cmd           = ADD;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub_comp();
    test_logic();
    test_rshft();
    test_back_to_back();
    test_random();
    test_reset_wins();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
